// File: rtl/stream_pkg.sv
// Shared definitions for the raster stream blocks: coordinate widths,
// a constant log2 helper and the stream_source state encoding.
package stream_pkg;

   localparam int V_BITW = 10;
   localparam int H_BITW = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_t;

   // Ceiling log2, intended for constant (elaboration-time) expressions.
   function automatic int log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with a registered occupancy count and a combinational head.
// Pushes while full and pops while empty are ignored.
module stream_fifo
   import stream_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int DEPTH     = 16,
   localparam int ADDR_W   = log2(DEPTH),
   localparam int CNT_W    = ADDR_W + 1
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 i_push,
   input  logic                 i_pop,
   input  logic [BIT_WIDTH-1:0] i_data,
   output logic [BIT_WIDTH-1:0] o_data,
   output logic [CNT_W-1:0]     o_count,
   output logic                 o_full,
   output logic                 o_empty
);

   logic [BIT_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0]    r_wr_ptr;
   logic [ADDR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic                 w_push;
   logic                 w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // NOTE: storage has no reset; only pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/stream_source.sv
// Raster stream transmitter: buffers pushed pixels and emits (vcnt, hcnt, pixel)
// over the full frame including blanking, stepping only when enable is high.
module stream_source
   import stream_pkg::*;
#(
   parameter int BIT_WIDTH    = 8,
   parameter int IMAGE_HEIGHT = 240,
   parameter int IMAGE_WIDTH  = 320,
   parameter int FRAME_HEIGHT = 262,
   parameter int FRAME_WIDTH  = 400,
   parameter int FIFO_DEPTH   = 16,
   parameter int START_LEVEL  = 8
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 run,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_pixel,
   output logic [BIT_WIDTH-1:0] out_pixel,
   output logic [V_BITW-1:0]    out_vcnt,
   output logic [H_BITW-1:0]    out_hcnt,
   output logic                 busy,
   output logic                 underflow
);

   localparam int CNT_W = log2(FIFO_DEPTH) + 1;
   localparam logic [V_BITW-1:0] V_LAST    = V_BITW'(FRAME_HEIGHT - 1);
   localparam logic [H_BITW-1:0] H_LAST    = H_BITW'(FRAME_WIDTH - 1);
   localparam logic [V_BITW-1:0] V_ACTIVE  = V_BITW'(IMAGE_HEIGHT);
   localparam logic [H_BITW-1:0] H_ACTIVE  = H_BITW'(IMAGE_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_START = CNT_W'(START_LEVEL);

   state_t               r_state;
   logic [V_BITW-1:0]    r_vcnt;
   logic [H_BITW-1:0]    r_hcnt;
   logic [BIT_WIDTH-1:0] r_pixel;
   logic                 r_busy;
   logic                 r_underflow;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic [CNT_W-1:0]     w_count;
   logic [BIT_WIDTH-1:0] w_head;
   logic                 w_h_wrap;
   logic                 w_frame_end;
   logic                 w_step;
   logic                 w_active;
   logic [V_BITW-1:0]    w_next_v;
   logic [H_BITW-1:0]    w_next_h;

   assign in_ready    = ~w_full;
   assign w_push      = in_valid & in_ready;
   assign w_h_wrap    = (r_hcnt == H_LAST);
   assign w_frame_end = w_h_wrap && (r_vcnt == V_LAST);
   assign w_next_h    = w_h_wrap ? '0 : r_hcnt + H_BITW'(1);
   assign w_next_v    = !w_h_wrap ? r_vcnt :
                        (r_vcnt == V_LAST) ? '0 : r_vcnt + V_BITW'(1);
   // Idle and freshly primed both park at the frame-end coordinate, so the
   // first step after either one lands on (0,0).
   assign w_step      = (r_state == RUN) && enable && !(w_frame_end && !run);
   assign w_active    = (w_next_v < V_ACTIVE) && (w_next_h < H_ACTIVE);
   assign w_pop       = w_step && w_active && !w_empty;

   stream_fifo #(
      .BIT_WIDTH (BIT_WIDTH),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (in_pixel),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_vcnt      <= V_LAST;
         r_hcnt      <= H_LAST;
         r_pixel     <= '0;
         r_busy      <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (run) begin
                  r_state     <= PRIME;
                  r_busy      <= 1'b1;
                  r_underflow <= 1'b0;
               end
            end
            PRIME: begin
               if (!run) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (w_count >= CNT_START) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (w_frame_end && !run) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else if (enable) begin
                  r_vcnt  <= w_next_v;
                  r_hcnt  <= w_next_h;
                  r_pixel <= w_pop ? w_head : '0;
                  // An empty FIFO never stalls the raster; it only flags the gap.
                  if (w_active && w_empty) r_underflow <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign out_pixel = r_pixel;
   assign out_vcnt  = r_vcnt;
   assign out_hcnt  = r_hcnt;
   assign busy      = r_busy;
   assign underflow = r_underflow;

endmodule

// File: tb/tb_stream_source.sv
// Directed bench: a full-size instance for reset and priming, and a 3x4 image /
// 5x6 frame instance for raster wrap, stall, underflow, full FIFO and run drop.
module tb_stream_source;
   import stream_pkg::*;

   localparam int BW = 8;
   localparam int IH = 3;
   localparam int IW = 4;
   localparam int FH = 5;
   localparam int FW = 6;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              f_rst, f_enable, f_run, f_in_valid, f_in_ready, f_busy, f_underflow;
   logic [BW-1:0]     f_in_pixel, f_out_pixel;
   logic [V_BITW-1:0] f_vcnt;
   logic [H_BITW-1:0] f_hcnt;

   logic              s_rst, s_enable, s_run, s_in_valid, s_in_ready, s_busy, s_underflow;
   logic [BW-1:0]     s_in_pixel, s_out_pixel;
   logic [V_BITW-1:0] s_vcnt;
   logic [H_BITW-1:0] s_hcnt;

   stream_source u_dut_full (
      .clock     (clock),
      .rst       (f_rst),
      .enable    (f_enable),
      .run       (f_run),
      .in_valid  (f_in_valid),
      .in_ready  (f_in_ready),
      .in_pixel  (f_in_pixel),
      .out_pixel (f_out_pixel),
      .out_vcnt  (f_vcnt),
      .out_hcnt  (f_hcnt),
      .busy      (f_busy),
      .underflow (f_underflow)
   );

   stream_source #(
      .IMAGE_HEIGHT (IH),
      .IMAGE_WIDTH  (IW),
      .FRAME_HEIGHT (FH),
      .FRAME_WIDTH  (FW)
   ) u_dut (
      .clock     (clock),
      .rst       (s_rst),
      .enable    (s_enable),
      .run       (s_run),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .in_pixel  (s_in_pixel),
      .out_pixel (s_out_pixel),
      .out_vcnt  (s_vcnt),
      .out_hcnt  (s_hcnt),
      .busy      (s_busy),
      .underflow (s_underflow)
   );

   int            n_checks = 0;
   int            n_pass   = 0;
   int            push_idx, pop_idx, cur_v, cur_h;
   logic          exp_uf;
   logic [BW-1:0] exp_last;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Small instance: one edge, tracking which pushed values the DUT accepted.
   task automatic step();
      logic acc;
      acc = s_in_valid && s_in_ready;
      tick();
      if (acc) push_idx++;
      s_in_pixel = BW'(32 + push_idx);
   endtask

   // Small instance: one emitting edge, checked against the raster order and
   // the sequence of accepted pixels.
   task automatic emit(input string tag);
      int ev, eh;
      logic [BW-1:0] ep;
      eh = (cur_h == FW - 1) ? 0 : cur_h + 1;
      ev = (cur_h != FW - 1) ? cur_v : (cur_v == FH - 1) ? 0 : cur_v + 1;
      ep = '0;
      if (ev < IH && eh < IW) begin
         if (pop_idx < push_idx) begin
            ep = BW'(32 + pop_idx);
            pop_idx++;
         end else begin
            exp_uf = 1'b1;
         end
      end
      step();
      cur_v    = ev;
      cur_h    = eh;
      exp_last = ep;
      check(tag, {s_vcnt, s_hcnt, s_out_pixel}, {V_BITW'(ev), H_BITW'(eh), ep});
      check({tag, "_uf"}, s_underflow, exp_uf);
   endtask

   initial begin
      f_rst = 1'b1; f_enable = 1'b0; f_run = 1'b0; f_in_valid = 1'b0; f_in_pixel = '0;
      s_rst = 1'b1; s_enable = 1'b0; s_run = 1'b0; s_in_valid = 1'b0; s_in_pixel = '0;
      push_idx = 0; pop_idx = 0; cur_v = FH - 1; cur_h = FW - 1;
      exp_uf = 1'b0; exp_last = '0;

      // Reset values of the full-size instance, before any clock edge
      #2;
      check("f_reset_pos", {f_vcnt, f_hcnt}, {10'd261, 9'd399});
      check("f_reset_pix", f_out_pixel, 8'h00);
      check("f_reset_flags", {f_busy, f_underflow}, 2'b00);
      tick();
      tick();
      f_rst = 1'b0;
      tick();
      check("f_idle_ready_busy", {f_in_ready, f_busy}, 2'b10);

      // Priming: seven pixels are below the start level
      f_run = 1'b1; f_enable = 1'b1; f_in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         f_in_pixel = BW'(16 + i);
         tick();
      end
      check("prime7_pos", {f_vcnt, f_hcnt}, {10'd261, 9'd399});
      check("prime7_pix", f_out_pixel, 8'h00);
      check("prime7_busy_ready", {f_busy, f_in_ready}, 2'b11);
      f_in_pixel = 8'h17;
      tick();
      f_in_valid = 1'b0;
      check("prime8_pos", {f_vcnt, f_hcnt}, {10'd261, 9'd399});
      tick();
      check("prime_to_run_pos", {f_vcnt, f_hcnt}, {10'd261, 9'd399});
      tick();
      check("first_emit", {f_vcnt, f_hcnt, f_out_pixel}, {10'd0, 9'd0, 8'h10});
      tick();
      check("second_emit", {f_vcnt, f_hcnt, f_out_pixel}, {10'd0, 9'd1, 8'h11});

      // Asynchronous reset mid-stream, observed without a clock edge
      #3 f_rst = 1'b1;
      #1;
      check("async_reset_pos", {f_vcnt, f_hcnt}, {10'd261, 9'd399});
      check("async_reset_pix", f_out_pixel, 8'h00);
      check("async_reset_flags", {f_busy, f_underflow, f_in_ready}, 3'b001);

      // Small instance: prime with a continuous push stream
      tick();
      s_rst = 1'b0;
      tick();
      check("s_reset_pos", {s_vcnt, s_hcnt}, {10'd4, 9'd5});
      s_run = 1'b1; s_enable = 1'b1; s_in_valid = 1'b1;
      s_in_pixel = BW'(32 + push_idx);
      for (int i = 0; i < 9; i++) step();
      check("s_primed_pos", {s_vcnt, s_hcnt, s_out_pixel}, {10'd4, 9'd5, 8'h00});
      check("s_primed_busy", s_busy, 1'b1);

      // Two full frames kept fed, then the wrap back to (0,0)
      for (int k = 0; k < 2 * FH * FW; k++) emit("raster");
      emit("wrap_00");
      check("wrap_00_pos", {s_vcnt, s_hcnt}, {10'd0, 9'd0});
      for (int k = 0; k < 8; k++) emit("to_stall");

      // Stall at (1,2) with pushes stopped for good
      s_enable = 1'b0; s_in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_hold", {s_vcnt, s_hcnt, s_out_pixel}, {10'd1, 9'd2, exp_last});
      end
      s_enable = 1'b1;
      emit("after_stall");
      check("after_stall_pos", {s_vcnt, s_hcnt}, {10'd1, 9'd3});

      // Rest of this frame and the whole next frame drain the FIFO
      for (int k = 0; k < 20 + FH * FW; k++) emit("drain");
      check("uf_sticky", s_underflow, 1'b1);

      // Fill to full with the stream stalled at frame end
      s_enable = 1'b0; s_in_valid = 1'b1;
      for (int i = 0; i < 15; i++) step();
      check("ready_at_15", s_in_ready, 1'b1);
      step();
      check("full_not_ready", s_in_ready, 1'b0);
      s_in_pixel = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_ignores", s_in_ready, 1'b0);
      end
      s_in_valid = 1'b0;
      s_in_pixel = BW'(32 + push_idx);

      // Drop run mid-frame: the frame completes, then IDLE
      s_enable = 1'b1;
      for (int k = 0; k < 8; k++) emit("rundrop");
      s_run = 1'b0;
      for (int k = 0; k < 22; k++) emit("rundrop");
      step();
      check("idle_pos", {s_vcnt, s_hcnt, s_out_pixel}, {10'd4, 9'd5, 8'h00});
      check("idle_busy", s_busy, 1'b0);
      check("idle_uf_held", s_underflow, 1'b1);
      step();
      step();
      check("idle_stays", {s_vcnt, s_hcnt, s_busy}, {10'd4, 9'd5, 1'b0});

      // Re-prime clears underflow; four leftover pixels stay below start level
      s_run = 1'b1;
      step();
      check("reprime_flags", {s_busy, s_underflow}, 2'b10);
      step();
      step();
      check("reprime_wait", {s_vcnt, s_hcnt, s_out_pixel}, {10'd4, 9'd5, 8'h00});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
